// File: rtl/exmuldiv.sv
// exmuldiv: iterative 34-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Shift-add multiply and restoring divide share one {p,q} datapath on magnitudes; signs are fixed up in FIX.
module exmuldiv #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DWIDTH-1:0] rsval,
    input  logic [DWIDTH-1:0] rtval,
    input  logic              hiwr,
    input  logic              lowr,
    input  logic [DWIDTH-1:0] wrdata,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic              divzero,
    output logic [DWIDTH-1:0] hi,
    output logic [DWIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, nstate;
    logic [4:0] count;
    logic mul, sa, sb, bz, go, sgn;
    logic [DWIDTH-1:0] p, q, a, rsraw, rs_abs, rt_abs, diff, quo, rem;
    logic [DWIDTH:0] msum, madd, rsh;
    logic ge;
    logic [2*DWIDTH-1:0] prod;
    always_comb begin
        go = start & (state == IDLE);
        stall = go | busy;
        nstate = state == IDLE ? (start ? CALC : IDLE) :
                 state == CALC ? (count == 5'd31 ? FIX : CALC) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nstate;
    end
    // signed ops work on magnitudes; the unsigned ops pass operands through raw
    always_comb begin
        sgn = ~op[0];
        rs_abs = (sgn & rsval[DWIDTH-1]) ? -rsval : rsval;
        rt_abs = (sgn & rtval[DWIDTH-1]) ? -rtval : rtval;
        msum = {1'b0, p} + {1'b0, a};
        madd = q[0] ? msum : {1'b0, p};
        rsh = {p, q[DWIDTH-1]};
        ge = rsh >= {1'b0, a};
        diff = rsh[DWIDTH-1:0] - a;
        prod = (sa ^ sb) ? -{p, q} : {p, q};
        quo = (sa ^ sb) ? -q : q;
        rem = sa ? -p : p;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            divzero <= 1'b0;
            hi <= '0;
            lo <= '0;
            mul <= 1'b0;
            sa <= 1'b0;
            sb <= 1'b0;
            bz <= 1'b0;
            p <= '0;
            q <= '0;
            a <= '0;
            rsraw <= '0;
        end else begin
            busy <= nstate != IDLE;
            done <= state == FIX;
            if (go) begin
                mul <= ~op[1];
                sa <= sgn & rsval[DWIDTH-1];
                sb <= sgn & rtval[DWIDTH-1];
                bz <= rtval == '0;
                rsraw <= rsval;
                a <= op[1] ? rt_abs : rs_abs;
                q <= op[1] ? rs_abs : rt_abs;
                p <= '0;
                count <= '0;
                divzero <= 1'b0;
            end else if (state == IDLE) begin
                if (hiwr) hi <= wrdata;
                if (lowr) lo <= wrdata;
            end
            if (state == CALC) begin
                count <= count + 5'd1;
                p <= mul ? madd[DWIDTH:1] : (ge ? diff : rsh[DWIDTH-1:0]);
                q <= mul ? {madd[0], q[DWIDTH-1:1]} : {q[DWIDTH-2:0], ge};
            end
            if (state == FIX) begin
                hi <= mul ? prod[2*DWIDTH-1:DWIDTH] : (bz ? rsraw : rem);
                lo <= mul ? prod[DWIDTH-1:0] : (bz ? '1 : quo);
                divzero <= ~mul & bz;
            end
        end
    end
endmodule

// File: tb/tb_exmuldiv.sv
// tb_exmuldiv: directed and random checks of exmuldiv against an arithmetic reference model.
module tb_exmuldiv;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, hiwr = 1'b0, lowr = 1'b0;
    logic [1:0] op = '0;
    logic [31:0] rsval = '0, rtval = '0, wrdata = '0;
    logic stall, busy, done, divzero;
    logic [31:0] hi, lo;
    int checks = 0, errors = 0;

    exmuldiv dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rsval(rsval), .rtval(rtval),
        .hiwr(hiwr), .lowr(lowr), .wrdata(wrdata), .stall(stall), .busy(busy),
        .done(done), .divzero(divzero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] h, output logic [31:0] l, output logic dz);
        longint sx, sy;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        if (o[1] && y == 0) begin
            h = x; l = 32'hFFFFFFFF; dz = 1'b1;
        end else if (o == 2'd0) begin
            r = sx * sy; h = r[63:32]; l = r[31:0];
        end else if (o == 2'd1) begin
            r = {32'b0, x} * {32'b0, y}; h = r[63:32]; l = r[31:0];
        end else if (o == 2'd2) begin
            r = sx / sy; l = r[31:0];
            r = sx % sy; h = r[31:0];
        end else begin
            l = x / y; h = x % y;
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit poke, input bit wrs);
        logic [31:0] eh, el;
        logic edz;
        int n;
        model(o, x, y, eh, el, edz);
        @(negedge clk);
        start = 1'b1; op = o; rsval = x; rtval = y; lowr = wrs; wrdata = 32'h5A5A0F0F;
        #1 chk("stall_pre", stall, 1);
        @(posedge clk); #1;
        start = 1'b0; lowr = 1'b0;
        chk("busy_e0", busy, 1);
        wrdata = 32'hDEADBEEF;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (poke) begin
                start = (n == 5); hiwr = (n == 5); rsval = ~x;
            end
            @(posedge clk); #1;
        end
        chk("busy_cycles", n, 33);
        chk("done", done, 1);
        chk("hi", hi, eh);
        chk("lo", lo, el);
        chk("divzero", divzero, edz);
        chk("stall_post", stall, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_divzero", divzero, 0);
        chk("rst_stall", stall, 0);
    endtask

    task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
        logic [31:0] oh, ol;
        oh = hi; ol = lo;
        @(negedge clk); hiwr = hw; lowr = lw; wrdata = d;
        #1 chk("mt_hi_pre", hi, oh);
        chk("mt_lo_pre", lo, ol);
        @(posedge clk); #1; hiwr = 1'b0; lowr = 1'b0;
        chk("mt_hi", hi, hw ? d : oh);
        chk("mt_lo", lo, lw ? d : ol);
    endtask

    initial begin
        logic [1:0] o;
        logic [31:0] x, y;
        repeat (2) @(posedge clk);
        do_reset();
        do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        @(posedge clk); #1;
        chk("done_fall", done, 0);
        chk("hi_hold", hi, 32'hFFFFFFFE);
        // reset lands on E10 of a running multiply
        @(negedge clk); start = 1'b1; op = 2'd0; rsval = 32'd123; rtval = 32'd456;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("mid_hi", hi, 0);
        chk("mid_lo", lo, 0);
        chk("mid_busy", busy, 0);
        chk("mid_stall", stall, 0);
        do_op(2'd0, 32'hFFFFFFF9, 32'd3, 0, 0);
        do_op(2'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
        do_op(2'd3, 32'd100, 32'd7, 0, 0);
        do_op(2'd3, 32'd5, 32'd0, 0, 0);
        do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        do_op(2'd2, 32'hFFFFFFF0, 32'd0, 0, 0);
        mt(1'b0, 1'b1, 32'hA5A5A5A5);
        mt(1'b1, 1'b0, 32'h12345678);
        mt(1'b1, 1'b1, 32'h0BADF00D);
        do_op(2'd0, 32'h00012345, 32'hFFFF0001, 1, 0);
        do_op(2'd3, 32'hCAFEBABE, 32'd17, 0, 1);
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                2: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                3: y = -32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(o, x, y, i % 7 == 3, i % 5 == 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exmuldiv.md
# exmuldiv

EX-stage iterative multiply/divide unit that consumes the operand and opcode fields issued by the ID/EX pipeline register. It executes MULT, MULTU, DIV and DIVU over a fixed 34-cycle sequence and holds the architectural HI/LO registers. It raises a combinational stall so that IF, ID and ID/EX hold their contents while the operation runs. MTHI and MTLO write HI and LO directly; MFHI and MFLO read them through the `hi` and `lo` ports.

## Interface
- DWIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  begin an operation; sampled only in IDLE
- op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rsval  input  DWIDTH  multiplicand or dividend, taken from the ID/EX regdata1 output
- rtval  input  DWIDTH  multiplier or divisor, taken from the ID/EX regdata2 output
- hiwr  input  1  MTHI: write wrdata to HI
- lowr  input  1  MTLO: write wrdata to LO
- wrdata  input  DWIDTH  data for MTHI and MTLO
- stall  output  1  combinational; equals (start & state==IDLE) | busy
- busy  output  1  registered; high in CALC and FIX
- done  output  1  registered; one-cycle pulse after HI/LO are written
- divzero  output  1  registered; set with done when a DIV or DIVU had rtval==0, held until the next start
- hi  output  DWIDTH  HI register
- lo  output  DWIDTH  LO register

## Operation
- State machine states:
  - IDLE: start=1 captures op, |rsval| and |rtval| (raw values for the unsigned ops) and both operand signs, clears count, then moves to CALC.
  - CALC: one iteration per cycle, count 0..31; count==31 moves to FIX.
  - FIX: applies sign correction, writes HI/LO, sets done=1, then moves to IDLE.
- Multiply (shift-add):
  - 64-bit accumulator {P,Q}, with Q loaded from the multiplier.
  - Each cycle, if Q[0] then P += multiplicand (33-bit add, keep the carry), then shift {carry,P,Q} right by 1.
  - Result: HI={P}, LO={Q}.
  - Signed ops: negate the 64-bit result iff the operand signs differ.
- Divide (restoring):
  - Remainder R is 33 bits; Q is loaded from the dividend.
  - Each cycle, shift {R,Q} left by 1, then trial = R − divisor; if trial≥0 then R=trial and Q[0]=1.
  - Result: LO=quotient, HI=remainder.
  - Signed ops: negate the quotient iff the signs differ; the remainder takes the dividend's sign.
- Divide by zero: HI=rsval, LO=32'hFFFFFFFF and divzero=1, for both DIV and DIVU; the unit still takes the full 34 cycles.
- −2^31 / −1 under DIV gives LO=32'h80000000, HI=0, with no flag.
- All add, subtract and negate operations are modulo 2^width; there is no overflow detection.
- MTHI/MTLO:
  - Honoured in IDLE only when start=0.
  - Writes during busy are ignored.
  - start and hiwr/lowr together in IDLE: start wins and the write is dropped.
  - hiwr and lowr together write both registers.
- start while busy is ignored, with no queuing.
- Reset, including mid-operation: state=IDLE, count=0, hi=0, lo=0, busy=0, done=0, divzero=0. The operation in flight is discarded.

## Timing
- Edge E0: start sampled in IDLE. stall is already high during the cycle before E0 (combinational).
- busy is high from E0 through E33, i.e. 33 cycles: CALC occupies E1..E32 and FIX is exited at E33.
- hi/lo update at E33. done=1 for exactly the cycle between E33 and E34.
- stall drops in the cycle after E33, so the EX instruction following MULT or DIV reads new HI/LO with no forwarding path.
- Back-to-back: start asserted in the done cycle is accepted; that edge is the next E0.
- MTHI/MTLO take effect at the next edge, so hi/lo change one cycle after the write cycle.
- hi and lo change only at E33, on an MTHI/MTLO edge, or at reset.

## Test plan
- Reset mid-CALC (at E10) -> hi=lo=0, busy=0 and stall=0 on the next cycle; a new start is accepted immediately.
- MULTU with rsval=32'hFFFFFFFF, rtval=32'hFFFFFFFF -> at E33 HI=32'hFFFFFFFE, LO=32'h00000001; done pulses once; busy is high for exactly 33 cycles.
- MULT with rsval=−7 (32'hFFFFFFF9), rtval=3 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
- DIV with rsval=−7, rtval=2 -> LO=32'hFFFFFFFD (−3), HI=32'hFFFFFFFF (−1). DIVU with 100/7 -> LO=14, HI=2.
- DIVU with rsval=5, rtval=0 -> HI=5, LO=32'hFFFFFFFF, divzero=1. DIV with 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0, divzero=0.
- In IDLE, lowr=1 with wrdata=32'hA5A5A5A5 -> lo updates on the next cycle. Mid-operation start=1 plus hiwr=1 -> both ignored, and the result matches the first operation. start and lowr together in IDLE -> the operation runs and the write is lost.
